// File: rtl/alu_pkg.sv
// Shared encodings for the ripple ALU and the multiply/divide sequencer.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Carry out of the MSB rebuilt from the operand and result MSBs, so the ALU cout is not needed.
  function automatic logic add_carry(input logic a, input logic b, input logic r);
    return (a & b) | ((a | b) & ~r);
  endfunction

  function automatic logic sub_no_borrow(input logic a, input logic b, input logic r);
    return (a & ~b) | ((a | ~b) & ~r);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One shift-add (multiply) or restoring shift-subtract (divide) iteration around the external ALU.
module muldiv_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             mode_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic [WIDTH-1:0] alu_src1_o,
  output logic [WIDTH-1:0] alu_src2_o,
  output logic [3:0]       alu_ctrl_o,
  output logic             carry_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] addend;
  logic             take;

  always_comb begin
    sh         = {hi_i[WIDTH-2:0], lo_i[WIDTH-1]};
    addend     = lo_i[0] ? opnd_i : '0;
    alu_src1_o = hi_i;
    alu_src2_o = addend;
    alu_ctrl_o = ALU_ADD;
    carry_o    = 1'b0;
    take       = 1'b0;
    hi_o       = hi_i;
    lo_o       = lo_i;
    if (mode_i == OP_DIV) begin
      alu_src1_o = sh;
      alu_src2_o = opnd_i;
      alu_ctrl_o = ALU_SUB;
      carry_o    = sub_no_borrow(sh[WIDTH-1], opnd_i[WIDTH-1], alu_result_i[WIDTH-1]);
      // A bit shifted out of rem means the partial remainder already exceeds the divisor.
      take       = hi_i[WIDTH-1] | carry_o;
      hi_o       = take ? alu_result_i : sh;
      lo_o       = {lo_i[WIDTH-2:0], take};
    end else begin
      carry_o = add_carry(hi_i[WIDTH-1], addend[WIDTH-1], alu_result_i[WIDTH-1]);
      hi_o    = {carry_o, alu_result_i[WIDTH-1:1]};
      lo_o    = {alu_result_i[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply/divide sequencer that borrows the datapath ALU, one iteration per clock.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ITER_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result
);

  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH - 1);

  state_t            state_q, state_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic              op_q, op_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;
  logic [WIDTH-1:0]  res_hi_q, res_hi_d;
  logic [WIDTH-1:0]  res_lo_q, res_lo_d;
  logic              div_zero_q, div_zero_d;

  logic [WIDTH-1:0]  step_src1, step_src2, step_hi, step_lo;
  logic [3:0]        step_ctrl;
  logic              unused_step_carry;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .mode_i       (op_q),
    .hi_i         (hi_q),
    .lo_i         (lo_q),
    .opnd_i       (opnd_q),
    .alu_result_i (alu_result),
    .alu_src1_o   (step_src1),
    .alu_src2_o   (step_src2),
    .alu_ctrl_o   (step_ctrl),
    .carry_o      (unused_step_carry),
    .hi_o         (step_hi),
    .lo_o         (step_lo)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_MUL;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      res_hi_q   <= '0;
      res_lo_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opnd_q     <= opnd_d;
      res_hi_q   <= res_hi_d;
      res_lo_q   <= res_lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opnd_d     = opnd_q;
    res_hi_d   = res_hi_q;
    res_lo_d   = res_lo_q;
    div_zero_d = div_zero_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d       = op;
          cnt_d      = '0;
          div_zero_d = 1'b0;
          if (op == OP_DIV && opb == '0) begin
            // Divide by zero completes immediately with an all-ones quotient.
            res_lo_d   = '1;
            res_hi_d   = opa;
            div_zero_d = 1'b1;
            state_d    = ST_DONE;
          end else if (op == OP_DIV) begin
            hi_d    = '0;
            lo_d    = opa;
            opnd_d  = opb;
            state_d = ST_RUN;
          end else begin
            hi_d    = '0;
            lo_d    = opb;
            opnd_d  = opa;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + ITER_W'(1);
        if (cnt_q == LAST_ITER) begin
          res_hi_d = step_hi;
          res_lo_d = step_lo;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign res_hi   = res_hi_q;
  assign res_lo   = res_lo_q;
  assign div_zero = div_zero_q;
  assign alu_src1 = busy ? step_src1 : '0;
  assign alu_src2 = busy ? step_src2 : '0;
  assign alu_ctrl = busy ? step_ctrl : ALU_AND;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq with a behavioural ripple ALU on the alu_* ports.
module tb_alu_muldiv_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op    = 1'b0;
  logic [W-1:0] opa   = '0;
  logic [W-1:0] opb   = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] res_hi, res_lo, alu_src1, alu_src2, alu_result;
  logic [3:0]   alu_ctrl;

  alu_muldiv_seq #(.WIDTH(W), .ITER_W(5)) dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .opa        (opa),
    .opb        (opb),
    .busy       (busy),
    .done       (done),
    .res_hi     (res_hi),
    .res_lo     (res_lo),
    .div_zero   (div_zero),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result)
  );

  always #5 clk_i = ~clk_i;

  // Stand-in for the existing ripple ALU.
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ALU_AND: alu_result = alu_src1 & alu_src2;
      ALU_OR:  alu_result = alu_src1 | alu_src2;
      ALU_ADD: alu_result = alu_src1 + alu_src2;
      ALU_SUB: alu_result = alu_src1 - alu_src2;
      ALU_SLT: alu_result = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
      ALU_NOR: alu_result = ~(alu_src1 | alu_src2);
      default: alu_result = '0;
    endcase
  end

  typedef struct {
    logic         op;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cyc;
    int           busy_len;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz);
    exp_t e;
    logic div0;
    @(negedge clk_i);
    div0       = (o == OP_DIV) && (b == '0);
    start      = 1'b1;
    op         = o;
    opa        = a;
    opb        = b;
    e.op       = o;
    e.hi       = ehi;
    e.lo       = elo;
    e.dz       = edz;
    e.cyc      = cyc + (div0 ? 1 : 33);
    e.busy_len = div0 ? 0 : 32;
    sb.push_back(e);
    $display("issue op=%0d a=0x%08h b=0x%08h expect hi=0x%08h lo=0x%08h dz=%0d", o, a, b, ehi, elo, edz);
    @(negedge clk_i);
    start = 1'b0;
  endtask

  task automatic pulse_start(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op    = o;
    opa   = a;
    opb   = b;
    @(negedge clk_i);
    start = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("completion_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  // Monitor: pops the scoreboard on each done pulse and watches the ALU drive every cycle.
  initial begin
    int   busy_cnt;
    exp_t e;
    busy_cnt = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_n) begin
        busy_cnt = 0;
      end else begin
        if (busy) begin
          busy_cnt++;
          if (sb.size() != 0)
            check("alu_ctrl_run", 64'(alu_ctrl), 64'(sb[0].op == OP_DIV ? ALU_SUB : ALU_ADD));
        end else begin
          check("alu_idle_drive", {alu_ctrl, alu_src1, alu_src2}, 64'd0);
        end
        if (done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 64'(done), 64'd0);
          end else begin
            e = sb.pop_front();
            check("res_hi", 64'(res_hi), 64'(e.hi));
            check("res_lo", 64'(res_lo), 64'(e.lo));
            check("div_zero", 64'(div_zero), 64'(e.dz));
            check("done_cycle", 64'(cyc), 64'(e.cyc));
            check("busy_len", 64'(busy_cnt), 64'(e.busy_len));
            $display("done cycle=%0d hi=0x%08h lo=0x%08h dz=%0d busy=%0d", cyc, res_hi, res_lo, div_zero, busy_cnt);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("reset_outputs", {busy, done, div_zero, res_hi, res_lo[28:0]}, 64'd0);
    check("reset_alu", {alu_ctrl, alu_src1, alu_src2}, 64'd0);
    repeat (3) @(negedge clk_i);
    rst_n = 1'b1;

    issue(OP_MUL, 32'd7, 32'd6, 32'h0, 32'h2A, 1'b0);
    wait_empty();
    issue(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    wait_empty();
    issue(OP_MUL, 32'h80000000, 32'd2, 32'h1, 32'h0, 1'b0);
    wait_empty();
    issue(OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    wait_empty();
    issue(OP_DIV, 32'hFFFFFFFF, 32'd1, 32'h0, 32'hFFFFFFFF, 1'b0);
    wait_empty();
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0);
    wait_empty();
    issue(OP_DIV, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0);
    wait_empty();
    issue(OP_DIV, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b1);
    wait_empty();
    issue(OP_MUL, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0);
    wait_empty();

    // Starts during RUN must be ignored; a divide-by-zero here would end the run early.
    issue(OP_MUL, 32'd5, 32'd9, 32'h0, 32'd45, 1'b0);
    repeat (3) @(negedge clk_i);
    check("busy_mid_run", 64'(busy), 64'd1);
    pulse_start(OP_DIV, 32'hDEAD, 32'd0);
    repeat (14) @(negedge clk_i);
    pulse_start(OP_MUL, 32'd3, 32'd3);
    wait_empty();
    repeat (5) @(negedge clk_i);

    // Asynchronous reset in the middle of a divide.
    issue(OP_DIV, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);
    repeat (9) @(posedge clk_i);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {busy, done, div_zero, res_hi, res_lo[28:0]}, 64'd0);
    check("async_reset_alu", {alu_ctrl, alu_src1, alu_src2}, 64'd0);
    sb.delete();
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1;
    repeat (40) @(negedge clk_i);
    check("no_done_after_reset", {res_hi, res_lo}, 64'd0);
    issue(OP_DIV, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);
    wait_empty();
    repeat (3) @(negedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
